// File: rtl/ddr4_v2_2_20_mc_ecc_dec_fix_if.sv
// Read-path bus between the PHY read pipe and the UI read buffer for the MC ECC decoder.
// Carries the incoming beat (data+check, tag, end) and the corrected beat with per-word flags.
interface ddr4_v2_2_20_mc_ecc_dec_fix_if #(
    parameter int PAYLOAD_WIDTH       = 64,
    parameter int DATA_BUF_ADDR_WIDTH = 5,
    parameter int DQ_WIDTH            = 72,
    parameter int nCK_PER_CLK         = 4
);
    localparam int NW = 2 * nCK_PER_CLK;

    logic [NW*DQ_WIDTH-1:0]      rd_data_in;
    logic                        rd_data_in_vld;
    logic [DATA_BUF_ADDR_WIDTH-1:0] rd_data_in_addr;
    logic                        rd_data_in_end;

    logic [NW*PAYLOAD_WIDTH-1:0] rd_data;
    logic                        rd_data_vld;
    logic [DATA_BUF_ADDR_WIDTH-1:0] rd_data_addr;
    logic                        rd_data_end;
    logic [NW-1:0]               ecc_single;
    logic [NW-1:0]               ecc_multiple;

    modport master (
        output rd_data_in, rd_data_in_vld, rd_data_in_addr, rd_data_in_end,
        input  rd_data, rd_data_vld, rd_data_addr, rd_data_end, ecc_single, ecc_multiple
    );

    modport slave (
        input  rd_data_in, rd_data_in_vld, rd_data_in_addr, rd_data_in_end,
        output rd_data, rd_data_vld, rd_data_addr, rd_data_end, ecc_single, ecc_multiple
    );
endinterface

// File: rtl/ddr4_v2_2_20_mc_ecc_dec_fix.sv
// SEC-DED read-path decoder/corrector: syndrome per word, single-bit fix, SBE/MBE flags and counters.
// Optional error log (tag + syndromes of first error beat) is built when ECC_ERR_LOG_EN is defined.
module ddr4_v2_2_20_mc_ecc_dec_fix #(
    parameter int TCQ                 = 100,
    parameter int PAYLOAD_WIDTH       = 64,
    parameter int CODE_WIDTH          = 72,
    parameter int DATA_BUF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 64,
    parameter int DQ_WIDTH            = 72,
    parameter int ECC_WIDTH           = 8,
    parameter int nCK_PER_CLK         = 4,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    ddr4_v2_2_20_mc_ecc_dec_fix_if.slave      bus,
    input  logic [2*nCK_PER_CLK-1:0]          raw_not_ecc,
    input  logic                              correct_en,
    input  logic [CODE_WIDTH*ECC_WIDTH-1:0]   h_rows,
    input  logic                              ecc_clr,
    output logic [CNT_WIDTH-1:0]              ecc_ce_cnt,
    output logic [CNT_WIDTH-1:0]              ecc_ue_cnt
`ifdef ECC_ERR_LOG_EN
    ,
    output logic                              ecc_err_vld,
    output logic [DATA_BUF_ADDR_WIDTH-1:0]    ecc_err_addr,
    output logic [2*nCK_PER_CLK*ECC_WIDTH-1:0] ecc_err_syndrome
`endif
);
    localparam int NW = 2 * nCK_PER_CLK;
    localparam int XW = DATA_WIDTH + ECC_WIDTH;
    localparam int WW = (PAYLOAD_WIDTH > XW) ? PAYLOAD_WIDTH : XW;
    localparam int unused_tcq = TCQ;

    // Check-bit columns of H never steer data correction; only the data part of each row is read.
    logic unused_h_ok;
    assign unused_h_ok = ^h_rows;

    // ---- stage 1: register the incoming beat ----
    logic [NW*DQ_WIDTH-1:0]         data_p1_d, data_p1_q;
    logic                           vld_p1_d, vld_p1_q;
    logic [DATA_BUF_ADDR_WIDTH-1:0] addr_p1_d, addr_p1_q;
    logic                           end_p1_d, end_p1_q;
    logic [NW-1:0]                  raw_p1_d, raw_p1_q;
    logic                           corr_p1_d, corr_p1_q;
    logic                           clr_p1_d, clr_p1_q;

    always_comb begin
        data_p1_d = bus.rd_data_in;
        vld_p1_d  = bus.rd_data_in_vld;
        addr_p1_d = bus.rd_data_in_addr;
        end_p1_d  = bus.rd_data_in_end;
        raw_p1_d  = raw_not_ecc;
        corr_p1_d = correct_en;
        clr_p1_d  = ecc_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            addr_p1_q <= '0;
            end_p1_q  <= 1'b0;
            raw_p1_q  <= '0;
            corr_p1_q <= 1'b0;
            clr_p1_q  <= 1'b0;
        end else begin
            data_p1_q <= data_p1_d;
            vld_p1_q  <= vld_p1_d;
            addr_p1_q <= addr_p1_d;
            end_p1_q  <= end_p1_d;
            raw_p1_q  <= raw_p1_d;
            corr_p1_q <= corr_p1_d;
            clr_p1_q  <= clr_p1_d;
        end
    end

    // ---- stage 2: syndrome, classification and correction ----
    logic [ECC_WIDTH-1:0]        h_col [DATA_WIDTH];
    logic [ECC_WIDTH-1:0]        syn   [NW];
    logic [NW-1:0]               sbe, mbe;
    logic [DATA_WIDTH-1:0]       dat_w, fix_w;
    logic [ECC_WIDTH-1:0]        chk_w;
    logic [WW-1:0]               word_w;
    logic [NW*PAYLOAD_WIDTH-1:0] payload;
    logic [NW*ECC_WIDTH-1:0]     syn_all;
    logic                        beat_sbe, beat_mbe;

    always_comb begin
        h_col = '{default: '0};
        for (int i = 0; i < DATA_WIDTH; i++)
            for (int k = 0; k < ECC_WIDTH; k++)
                h_col[i][k] = h_rows[k*CODE_WIDTH+i];
    end

    always_comb begin
        syn     = '{default: '0};
        sbe     = '0;
        mbe     = '0;
        payload = '0;
        syn_all = '0;
        dat_w   = '0;
        chk_w   = '0;
        fix_w   = '0;
        word_w  = '0;
        for (int j = 0; j < NW; j++) begin
            dat_w = data_p1_q[j*DATA_WIDTH +: DATA_WIDTH];
            chk_w = data_p1_q[NW*DATA_WIDTH + j*ECC_WIDTH +: ECC_WIDTH];
            for (int k = 0; k < ECC_WIDTH; k++)
                syn[j][k] = ^(dat_w & h_rows[k*CODE_WIDTH +: DATA_WIDTH]) ^ chk_w[ECC_WIDTH-1-k];
            if (raw_p1_q[j])
                syn[j] = '0;
            sbe[j] = ^syn[j];
            mbe[j] = (syn[j] != '0) && !(^syn[j]);
            // A check-bit error matches no data column, so the data falls through untouched.
            fix_w = dat_w;
            if (sbe[j] && corr_p1_q)
                for (int i = 0; i < DATA_WIDTH; i++)
                    if (h_col[i] == syn[j])
                        fix_w[i] = ~dat_w[i];
            word_w = '0;
            if (raw_p1_q[j])
                word_w[XW-1:0] = {chk_w, dat_w};
            else
                word_w[DATA_WIDTH-1:0] = fix_w;
            payload[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = PAYLOAD_WIDTH'(word_w);
            syn_all[j*ECC_WIDTH +: ECC_WIDTH] = syn[j];
        end
        beat_mbe = vld_p1_q && (mbe != '0);
        beat_sbe = vld_p1_q && (sbe != '0) && (mbe == '0);
    end

    logic [NW*PAYLOAD_WIDTH-1:0]    rd_data_d, rd_data_q;
    logic                           rd_vld_d, rd_vld_q;
    logic [DATA_BUF_ADDR_WIDTH-1:0] rd_addr_d, rd_addr_q;
    logic                           rd_end_d, rd_end_q;
    logic [NW-1:0]                  single_d, single_q;
    logic [NW-1:0]                  multiple_d, multiple_q;
    logic [CNT_WIDTH-1:0]           ce_cnt_d, ce_cnt_q, ce_base;
    logic [CNT_WIDTH-1:0]           ue_cnt_d, ue_cnt_q, ue_base;

    always_comb begin
        rd_data_d  = payload;
        rd_vld_d   = vld_p1_q;
        rd_addr_d  = addr_p1_q;
        rd_end_d   = end_p1_q;
        single_d   = vld_p1_q ? sbe : '0;
        multiple_d = vld_p1_q ? mbe : '0;
        // Clear takes effect before the same beat's error is counted.
        ce_base    = clr_p1_q ? '0 : ce_cnt_q;
        ue_base    = clr_p1_q ? '0 : ue_cnt_q;
        ce_cnt_d   = (beat_sbe && (ce_base != '1)) ? ce_base + CNT_WIDTH'(1) : ce_base;
        ue_cnt_d   = (beat_mbe && (ue_base != '1)) ? ue_base + CNT_WIDTH'(1) : ue_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_end_q   <= 1'b0;
            single_q   <= '0;
            multiple_q <= '0;
            ce_cnt_q   <= '0;
            ue_cnt_q   <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            rd_end_q   <= rd_end_d;
            single_q   <= single_d;
            multiple_q <= multiple_d;
            ce_cnt_q   <= ce_cnt_d;
            ue_cnt_q   <= ue_cnt_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_data_vld  = rd_vld_q;
    assign bus.rd_data_addr = rd_addr_q;
    assign bus.rd_data_end  = rd_end_q;
    assign bus.ecc_single   = single_q;
    assign bus.ecc_multiple = multiple_q;
    assign ecc_ce_cnt       = ce_cnt_q;
    assign ecc_ue_cnt       = ue_cnt_q;

`ifdef ECC_ERR_LOG_EN
    logic                           log_vld_d, log_vld_q;
    logic                           log_mbe_d, log_mbe_q;
    logic [DATA_BUF_ADDR_WIDTH-1:0] log_addr_d, log_addr_q;
    logic [NW*ECC_WIDTH-1:0]        log_syn_d, log_syn_q;

    // An SBE-only entry may be upgraded by one later MBE beat; an MBE entry is final.
    always_comb begin
        log_vld_d  = clr_p1_q ? 1'b0 : log_vld_q;
        log_mbe_d  = clr_p1_q ? 1'b0 : log_mbe_q;
        log_addr_d = clr_p1_q ? '0 : log_addr_q;
        log_syn_d  = clr_p1_q ? '0 : log_syn_q;
        if ((beat_sbe || beat_mbe) && (!log_vld_d || (beat_mbe && !log_mbe_d))) begin
            log_vld_d  = 1'b1;
            log_mbe_d  = beat_mbe;
            log_addr_d = addr_p1_q;
            log_syn_d  = syn_all;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_vld_q  <= 1'b0;
            log_mbe_q  <= 1'b0;
            log_addr_q <= '0;
            log_syn_q  <= '0;
        end else begin
            log_vld_q  <= log_vld_d;
            log_mbe_q  <= log_mbe_d;
            log_addr_q <= log_addr_d;
            log_syn_q  <= log_syn_d;
        end
    end

    assign ecc_err_vld      = log_vld_q;
    assign ecc_err_addr     = log_addr_q;
    assign ecc_err_syndrome = log_syn_q;
`else
    logic unused_syn_ok;
    assign unused_syn_ok = ^syn_all;
`endif
endmodule

// File: tb/tb_ddr4_v2_2_20_mc_ecc_dec_fix.sv
// Scoreboard bench for the ECC read decoder: expectations come from injected error masks.
`timescale 1ns/1ps
module tb_ddr4_v2_2_20_mc_ecc_dec_fix;
    localparam int NW = 8, DW = 64, EW = 8, CW = 72, DQW = 72, PW = 72, AW = 5, CNTW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NW-1:0]     raw_not_ecc = '0;
    logic              correct_en = 1'b1;
    logic              ecc_clr = 1'b0;
    logic [CW*EW-1:0]  h_rows;
    logic [CNTW-1:0]   ecc_ce_cnt, ecc_ue_cnt;
`ifdef ECC_ERR_LOG_EN
    logic              ecc_err_vld;
    logic [AW-1:0]     ecc_err_addr;
    logic [NW*EW-1:0]  ecc_err_syndrome;
`endif

    ddr4_v2_2_20_mc_ecc_dec_fix_if #(.PAYLOAD_WIDTH(PW), .DATA_BUF_ADDR_WIDTH(AW),
        .DQ_WIDTH(DQW), .nCK_PER_CLK(4)) bus ();

    ddr4_v2_2_20_mc_ecc_dec_fix #(.PAYLOAD_WIDTH(PW), .CODE_WIDTH(CW), .DATA_BUF_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .DQ_WIDTH(DQW), .ECC_WIDTH(EW), .nCK_PER_CLK(4), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .raw_not_ecc(raw_not_ecc), .correct_en(correct_en),
        .h_rows(h_rows), .ecc_clr(ecc_clr), .ecc_ce_cnt(ecc_ce_cnt), .ecc_ue_cnt(ecc_ue_cnt)
`ifdef ECC_ERR_LOG_EN
        , .ecc_err_vld(ecc_err_vld), .ecc_err_addr(ecc_err_addr), .ecc_err_syndrome(ecc_err_syndrome)
`endif
    );

    typedef struct {
        logic [NW*PW-1:0] pl;
        logic [NW-1:0]    s, m;
        logic [AW-1:0]    a;
        logic             e;
        logic [CNTW-1:0]  ce, ue;
        logic             lv;
        logic [AW-1:0]    la;
        logic [NW*EW-1:0] ls;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_cmp = 0, n_err = 0;

    logic [EW-1:0] hcol [DW];
    logic [DW-1:0] bd  [NW];
    logic [DW-1:0] bed [NW];
    logic [EW-1:0] bec [NW];

    int m_ce = 0, m_ue = 0;
    logic m_lv = 1'b0, m_lm = 1'b0;
    logic [AW-1:0] m_la = '0;
    logic [NW*EW-1:0] m_ls = '0;

    task automatic chk(input string name, input logic [NW*PW-1:0] act, input logic [NW*PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
        logic [EW-1:0] c = '0;
        for (int k = 0; k < EW; k++)
            for (int i = 0; i < DW; i++)
                if (d[i] && hcol[i][k]) c[EW-1-k] = ~c[EW-1-k];
        return c;
    endfunction

    function automatic logic [EW-1:0] syn_of(input logic [DW-1:0] ed, input logic [EW-1:0] ec);
        logic [EW-1:0] s = '0;
        for (int i = 0; i < DW; i++) if (ed[i]) s ^= hcol[i];
        for (int p = 0; p < EW; p++) if (ec[p]) s[EW-1-p] = ~s[EW-1-p];
        return s;
    endfunction

    task automatic send(input logic [NW-1:0] raw, input logic corr, input logic clr,
                        input logic [AW-1:0] tag, input logic last, input logic push);
        logic [NW*DQW-1:0] din;
        exp_t e;
        logic [NW-1:0] sf, mf;
        logic [NW*EW-1:0] syns;
        int w;
        e = '{default: '0};
        sf = '0; mf = '0; syns = '0;
        for (int j = 0; j < NW; j++) begin
            din[j*DW +: DW]      = bd[j] ^ bed[j];
            din[NW*DW + j*EW +: EW] = enc(bd[j]) ^ bec[j];
        end
        @(posedge clk); #1;
        bus.rd_data_in = din; bus.rd_data_in_vld = 1'b1; bus.rd_data_in_addr = tag;
        bus.rd_data_in_end = last; raw_not_ecc = raw; correct_en = corr; ecc_clr = clr;
        if (!push) return;
        for (int j = 0; j < NW; j++) begin
            w = $countones(bed[j]) + $countones(bec[j]);
            if (raw[j]) begin
                e.pl[j*PW +: PW] = {enc(bd[j]) ^ bec[j], bd[j] ^ bed[j]};
            end else begin
                syns[j*EW +: EW] = syn_of(bed[j], bec[j]);
                if (w == 1) begin
                    sf[j] = 1'b1;
                    e.pl[j*PW +: PW] = {8'h00, (corr && bed[j] != '0) ? bd[j] : bd[j] ^ bed[j]};
                end else if (w == 2) begin
                    mf[j] = 1'b1;
                    e.pl[j*PW +: PW] = {8'h00, bd[j] ^ bed[j]};
                end else begin
                    e.pl[j*PW +: PW] = {8'h00, bd[j]};
                end
            end
        end
        if (clr) begin
            m_ce = 0; m_ue = 0; m_lv = 0; m_lm = 0; m_la = '0; m_ls = '0;
        end
        if (mf != '0) m_ue = (m_ue < 15) ? m_ue + 1 : 15;
        else if (sf != '0) m_ce = (m_ce < 15) ? m_ce + 1 : 15;
        if ((sf | mf) != '0 && (!m_lv || (mf != '0 && !m_lm))) begin
            m_lv = 1; m_lm = (mf != '0); m_la = tag; m_ls = syns;
        end
        e.s = sf; e.m = mf; e.a = tag; e.e = last;
        e.ce = CNTW'(m_ce); e.ue = CNTW'(m_ue);
        e.lv = m_lv; e.la = m_la; e.ls = m_ls;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.rd_data_in_vld = 1'b0; ecc_clr = 1'b0;
        end
    endtask

    task automatic clean_words(input logic [DW-1:0] pat, input logic rnd);
        for (int j = 0; j < NW; j++) begin
            bd[j]  = rnd ? {$urandom, $urandom} : pat;
            bed[j] = '0;
            bec[j] = '0;
        end
    endtask

    task automatic inject(input int j, input int pos);
        if (pos < DW) bed[j][pos] = ~bed[j][pos];
        else          bec[j][pos-DW] = ~bec[j][pos-DW];
    endtask

    task automatic check_reset_state();
        chk("rst_vld", bus.rd_data_vld, 0);
        chk("rst_data", bus.rd_data, 0);
        chk("rst_flags", {bus.ecc_single, bus.ecc_multiple, bus.rd_data_addr, bus.rd_data_end}, 0);
        chk("rst_cnt", {ecc_ce_cnt, ecc_ue_cnt}, 0);
`ifdef ECC_ERR_LOG_EN
        chk("rst_log", {ecc_err_vld, ecc_err_addr, ecc_err_syndrome}, 0);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rd_data_vld) begin
            if (expq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_vld: got rd_data_vld=1 expected no beat");
            end else begin
                mon_e = expq.pop_front();
                chk("payload", bus.rd_data, mon_e.pl);
                chk("single", bus.ecc_single, mon_e.s);
                chk("multiple", bus.ecc_multiple, mon_e.m);
                chk("tag_end", {bus.rd_data_addr, bus.rd_data_end}, {mon_e.a, mon_e.e});
                chk("ce_cnt", ecc_ce_cnt, mon_e.ce);
                chk("ue_cnt", ecc_ue_cnt, mon_e.ue);
`ifdef ECC_ERR_LOG_EN
                chk("log", {ecc_err_vld, ecc_err_addr, ecc_err_syndrome}, {mon_e.lv, mon_e.la, mon_e.ls});
`endif
            end
        end
    end

    initial begin
        int n = 0;
        for (int v = 1; v < 256; v++)
            if (($countones(v) % 2 == 1) && ($countones(v) >= 3) && (n < DW)) begin
                hcol[n] = EW'(v);
                n++;
            end
        h_rows = '0;
        for (int k = 0; k < EW; k++) begin
            for (int i = 0; i < DW; i++) h_rows[k*CW+i] = hcol[i][k];
            h_rows[k*CW + DW + (EW-1-k)] = 1'b1;
        end
        bus.rd_data_in = '0; bus.rd_data_in_vld = 1'b0; bus.rd_data_in_addr = '0; bus.rd_data_in_end = 1'b0;

        repeat (3) @(posedge clk);
        #1 check_reset_state();
        rst_n = 1'b1;
        idle(2);

        // clean beat
        clean_words(64'hA5A5_A5A5_A5A5_A5A5, 0);
        send('0, 1, 0, 5'd1, 1, 1);
        // single data-bit error, corrected then detect-only
        clean_words(64'hA5A5_A5A5_A5A5_A5A5, 0);
        inject(2, 13);
        send('0, 1, 0, 5'd2, 0, 1);
        send('0, 0, 0, 5'd3, 1, 1);
        // double error
        clean_words(64'h0123_4567_89AB_CDEF, 0);
        inject(5, 0); inject(5, 1);
        send('0, 1, 0, 5'd4, 1, 1);
        // raw bypass with corrupted check bits
        clean_words(0, 1);
        for (int j = 0; j < NW; j++) bec[j] = EW'($urandom_range(1, 255));
        inject(0, 7);
        send(8'hFF, 1, 0, 5'd5, 1, 1);
        // counter saturation, then clear together with an error beat
        for (int b = 0; b < 20; b++) begin
            clean_words(0, 1);
            inject($urandom_range(0, NW-1), $urandom_range(0, DW-1));
            send('0, 1, 0, AW'(b), b == 19, 1);
        end
        clean_words(0, 1);
        inject(3, 70);
        send('0, 1, 1, 5'd9, 1, 1);
        idle(1);
        // log: clear, SBE at tag 3, MBE at tag 7
        clean_words(0, 1);
        send('0, 1, 1, 5'd0, 0, 1);
        inject(1, 40);
        send('0, 1, 0, 5'd3, 0, 1);
        clean_words(0, 1);
        inject(6, 2); inject(6, 66);
        send('0, 1, 0, 5'd7, 0, 1);
        clean_words(0, 1);
        inject(4, 9);
        send('0, 1, 0, 5'd8, 1, 1);
        idle(3);

        // randomized traffic
        for (int b = 0; b < 300; b++) begin
            clean_words(0, 1);
            for (int j = 0; j < NW; j++) begin
                int t = $urandom_range(0, 5);
                int p0 = $urandom_range(0, DQW-1);
                int p1 = (p0 + $urandom_range(1, DQW-1)) % DQW;
                if (t == 1 || t == 2) inject(j, p0);
                if (t == 3) begin inject(j, p0); inject(j, p1); end
            end
            send(($urandom_range(0, 3) == 0) ? NW'($urandom) : '0, NW'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15) == 0, AW'($urandom), 1'($urandom), 1);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        // reset with two beats in flight
        clean_words(0, 1);
        inject(0, 3);
        send('0, 1, 0, 5'd11, 0, 0);
        send('0, 1, 0, 5'd12, 1, 0);
        #3;
        rst_n = 1'b0;
        bus.rd_data_in_vld = 1'b0; ecc_clr = 1'b0;
        expq.delete();
        m_ce = 0; m_ue = 0; m_lv = 0; m_lm = 0; m_la = '0; m_ls = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_state();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_vld_after_rst", bus.rd_data_vld, 0);
        end
        clean_words(0, 1);
        inject(7, 20);
        send('0, 1, 0, 5'd13, 1, 1);
        idle(1);

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        chk("drain", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
